// File: rtl/instr_cache_ctrl.sv
// Direct-mapped instruction cache controller: zero-latency hit path,
// word-by-word line refill from memory, flush and saturating miss counter.
// Ports: clk_i, rst_ni (sync, active-low); CPU side req_i, addr_i, flush_i,
//   instr_o, ready_o; memory side mem_req_o, mem_addr_o, mem_ack_i,
//   mem_data_i; statistics miss_cnt_o.
module instr_cache_ctrl #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        flush_i,
    output logic [31:0] instr_o,
    output logic        ready_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [15:0] miss_cnt_o
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int TW = 32 - IW - OW - 2;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        DONE
    } state_t;

    state_t                state;
    logic [NUM_LINES-1:0]  valid;
    logic [TW-1:0]         tag_q  [NUM_LINES];
    logic [31:0]           data_q [NUM_LINES][LINE_WORDS];
    logic [TW-1:0]         miss_tag;
    logic [IW-1:0]         miss_index;
    logic [OW-1:0]         word_cnt;
    logic                  flush_pending;

    logic [TW-1:0]         addr_tag;
    logic [IW-1:0]         addr_index;
    logic [OW-1:0]         addr_off;
    logic                  hit;
    logic                  last_word;
    logic                  unused_byte;

    assign addr_tag    = addr_i[31 -: TW];
    assign addr_index  = addr_i[2+OW +: IW];
    assign addr_off    = addr_i[2 +: OW];
    assign unused_byte = ^addr_i[1:0];

    assign hit       = req_i & valid[addr_index]
                     & (tag_q[addr_index] == addr_tag);
    assign last_word = (word_cnt == OW'(LINE_WORDS - 1));

    // Hit path is combinational; a flush in the same cycle masks it.
    assign ready_o = (state == IDLE) & hit & ~flush_i;
    assign instr_o = data_q[addr_index][addr_off];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= IDLE;
            valid         <= '0;
            word_cnt      <= '0;
            flush_pending <= 1'b0;
            miss_cnt_o    <= '0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            miss_tag      <= '0;
            miss_index    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_i) begin
                        valid <= '0;
                    end else if (req_i && !hit) begin
                        miss_tag   <= addr_tag;
                        miss_index <= addr_index;
                        word_cnt   <= '0;
                        // Victim line is dead while it is being overwritten.
                        valid[addr_index] <= 1'b0;
                        if (miss_cnt_o != 16'hFFFF)
                            miss_cnt_o <= miss_cnt_o + 16'd1;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= {addr_tag, addr_index,
                                       {OW{1'b0}}, 2'b00};
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush_i)
                        flush_pending <= 1'b1;
                    if (mem_ack_i) begin
                        if (last_word) begin
                            valid[miss_index] <= ~(flush_pending | flush_i);
                            mem_req_o <= 1'b0;
                            state     <= DONE;
                        end else begin
                            word_cnt   <= word_cnt + 1'b1;
                            mem_addr_o <= {miss_tag, miss_index,
                                           word_cnt + 1'b1, 2'b00};
                        end
                    end
                end
                DONE: begin
                    if (flush_pending || flush_i)
                        valid <= '0;
                    flush_pending <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; validity is tracked by valid[].
    always_ff @(posedge clk_i) begin
        if (rst_ni && state == REFILL && mem_ack_i) begin
            data_q[miss_index][word_cnt] <= mem_data_i;
            if (last_word)
                tag_q[miss_index] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Directed self-checking bench for instr_cache_ctrl: cold miss, hit,
// conflict, ack stalls, flush in refill and idle, reset mid-refill.
module tb_instr_cache_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic [31:0] addr_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic        ready_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [15:0] miss_cnt_o;

    int checks   = 0;
    int failures = 0;

    instr_cache_ctrl #(.NUM_LINES(16), .LINE_WORDS(32)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .flush_i    (flush_i),
        .instr_o    (instr_o),
        .ready_o    (ready_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .miss_cnt_o (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents: unique per word address.
    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Serves nwords refill acks starting at base; optional random gaps and
    // a flush pulse alongside ack number flush_at. Ends at the DONE cycle
    // when the whole line was served.
    task automatic refill(input logic [31:0] base, input bit stall,
                          input int flush_at, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            int g;
            logic [31:0] wa;
            wa = base + 32'(4 * w);
            g  = stall ? int'($urandom_range(0, 3)) : 0;
            for (int k = 0; k < g; k++) begin
                @(negedge clk_i);
                mem_ack_i = 1'b0;
                flush_i   = 1'b0;
                #1;
                chkb("gap_req", mem_req_o, 1'b1);
                chk("gap_addr", mem_addr_o, wa);
            end
            @(negedge clk_i);
            mem_ack_i  = 1'b1;
            mem_data_i = f(wa);
            flush_i    = (w == flush_at);
            #1;
            chkb("ack_req", mem_req_o, 1'b1);
            chk("ack_addr", mem_addr_o, wa);
            chkb("refill_rdy", ready_o, 1'b0);
        end
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        flush_i   = 1'b0;
        if (nwords == 32) begin
            #1;
            chkb("done_req", mem_req_o, 1'b0);
            chkb("done_rdy", ready_o, 1'b0);
        end
    endtask

    // Starts a fetch at the next falling edge and expects a miss.
    task automatic fetch_miss(input logic [31:0] a, input logic [15:0] cnt);
        @(negedge clk_i);
        req_i  = 1'b1;
        addr_i = a;
        #1;
        chkb("miss_rdy", ready_o, 1'b0);
        chk("miss_cnt_before", 32'(miss_cnt_o), 32'(cnt));
    endtask

    // One cycle after DONE: held request must hit.
    task automatic expect_hit(input logic [31:0] a, input logic [15:0] cnt);
        @(negedge clk_i);
        #1;
        chkb("hit_rdy", ready_o, 1'b1);
        chk("hit_instr", instr_o, f({a[31:2], 2'b00}));
        chk("hit_cnt", 32'(miss_cnt_o), 32'(cnt));
    endtask

    initial begin
        rst_ni     = 1'b0;
        req_i      = 1'b0;
        addr_i     = '0;
        flush_i    = 1'b0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        chkb("rst_rdy", ready_o, 1'b0);
        chkb("rst_mreq", mem_req_o, 1'b0);
        chk("rst_maddr", mem_addr_o, 32'h0);
        chk("rst_cnt", 32'(miss_cnt_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Cold miss on 0x104
        fetch_miss(32'h0000_0104, 16'd0);
        refill(32'h0000_0100, 1'b0, -1, 32);
        expect_hit(32'h0000_0104, 16'd1);

        // Hit on another word of the same line
        @(negedge clk_i);
        addr_i = 32'h0000_0178;
        #1;
        chkb("hit30_rdy", ready_o, 1'b1);
        chk("hit30_instr", instr_o, f(32'h0000_0178));
        chkb("hit30_mreq", mem_req_o, 1'b0);
        chk("hit30_cnt", 32'(miss_cnt_o), 32'd1);

        // Stray ack in IDLE is ignored
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        chkb("stray_mreq", mem_req_o, 1'b0);
        chkb("stray_rdy", ready_o, 1'b1);
        chk("stray_cnt", 32'(miss_cnt_o), 32'd1);

        // No request -> not ready
        @(negedge clk_i);
        req_i = 1'b0;
        #1;
        chkb("noreq_rdy", ready_o, 1'b0);

        // Conflict: same index, tag 1, refill with stalls
        fetch_miss(32'h0000_0904, 16'd1);
        refill(32'h0000_0900, 1'b1, -1, 32);
        expect_hit(32'h0000_0904, 16'd2);
        fetch_miss(32'h0000_0104, 16'd2);
        refill(32'h0000_0100, 1'b1, -1, 32);
        expect_hit(32'h0000_0104, 16'd3);

        // Flush mid-refill: line ends up invalid, refetch misses
        fetch_miss(32'h0000_0208, 16'd3);
        refill(32'h0000_0200, 1'b1, 5, 32);
        @(negedge clk_i);
        #1;
        chkb("flushref_rdy", ready_o, 1'b0);
        chk("flushref_cnt", 32'(miss_cnt_o), 32'd4);
        refill(32'h0000_0200, 1'b0, -1, 32);
        expect_hit(32'h0000_0208, 16'd5);

        // Flush in IDLE: valid lines all miss, no miss counted
        @(negedge clk_i);
        addr_i = 32'h0000_0104;
        #1;
        chkb("preflush_rdy", ready_o, 1'b0);
        refill(32'h0000_0100, 1'b0, -1, 32);
        expect_hit(32'h0000_0104, 16'd6);
        @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        chkb("flush_rdy", ready_o, 1'b0);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        chkb("postflush_rdy", ready_o, 1'b0);
        chk("postflush_cnt", 32'(miss_cnt_o), 32'd6);
        chkb("postflush_mreq", mem_req_o, 1'b0);
        refill(32'h0000_0100, 1'b0, -1, 32);
        expect_hit(32'h0000_0104, 16'd7);
        fetch_miss(32'h0000_0208, 16'd7);
        refill(32'h0000_0200, 1'b0, -1, 32);
        expect_hit(32'h0000_0208, 16'd8);

        // Reset after 10 acks
        fetch_miss(32'h0000_0304, 16'd8);
        refill(32'h0000_0300, 1'b0, -1, 10);
        #1;
        chkb("partial_mreq", mem_req_o, 1'b1);
        chk("partial_addr", mem_addr_o, 32'h0000_0328);
        rst_ni = 1'b0;
        @(negedge clk_i);
        #1;
        chkb("midrst_mreq", mem_req_o, 1'b0);
        chk("midrst_cnt", 32'(miss_cnt_o), 32'd0);
        chkb("midrst_rdy", ready_o, 1'b0);
        rst_ni = 1'b1;
        refill(32'h0000_0300, 1'b0, -1, 32);
        expect_hit(32'h0000_0304, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_cache_ctrl.md
INSTR_CACHE_CTRL -- requirements
Module: instr_cache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, meaning number of direct-mapped lines (index width 4).
REQ-002 SHALL have parameter LINE_WORDS, default 32, meaning 32-bit words per line (offset width 5).
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port req_i, input, 1 bit: CPU fetch request.
REQ-006 SHALL have port addr_i, input, 32 bits: fetch byte address; {tag[31:11], index[10:7], offset[6:2], byte[1:0]}.
REQ-007 SHALL have port flush_i, input, 1 bit: invalidate all lines.
REQ-008 SHALL have port instr_o, output, 32 bits: fetched instruction.
REQ-009 SHALL have port ready_o, output, 1 bit: instr_o valid for current addr_i.
REQ-010 SHALL have port mem_req_o, output, 1 bit: refill word request to memory.
REQ-011 SHALL have port mem_addr_o, output, 32 bits: word-aligned refill address.
REQ-012 SHALL have port mem_ack_i, input, 1 bit: memory returns mem_data_i this cycle.
REQ-013 SHALL have port mem_data_i, input, 32 bits: refill data.
REQ-014 SHALL have port miss_cnt_o, output, 16 bits: saturating miss counter.

Function
REQ-015 SHALL hold per line: valid bit, 21-bit tag, LINE_WORDS x 32-bit data.
REQ-016 SHALL implement FSM states IDLE, REFILL, DONE.
REQ-017 IDLE: hit = req_i & valid[index] & (tag[index]==addr_i[31:11]); on hit ready_o=1 and instr_o=data[index][offset] combinationally, zero-cycle latency.
REQ-018 IDLE, req_i & miss & !flush_i: ready_o=0, latch miss tag/index, clear word counter, increment miss_cnt_o (saturate at 0xFFFF), go REFILL next cycle.
REQ-019 REFILL: mem_req_o=1, mem_addr_o={miss_tag, miss_index, word_cnt, 2'b00}; address stable until mem_ack_i.
REQ-020 REFILL, mem_ack_i: write mem_data_i to data[miss_index][word_cnt], word_cnt+1; back-to-back acks accepted, one word per ack.
REQ-021 Ack on word_cnt==LINE_WORDS-1: write last word, set tag, set valid unless flush pending, mem_req_o=0 next cycle, go DONE.
REQ-022 DONE: ready_o=0, go IDLE next cycle; the held request then hits per REQ-017.
REQ-023 ready_o SHALL be 0 in REFILL and DONE and whenever req_i=0.
REQ-024 mem_req_o SHALL be 0 outside REFILL; mem_ack_i outside REFILL ignored.
REQ-025 flush_i in IDLE: clear all valid bits next edge; ready_o=0 that cycle, no miss counted, no refill started.
REQ-026 flush_i in REFILL/DONE: set flush_pending; refill runs to completion; on DONE->IDLE all valid bits cleared including refilled line; flush_pending cleared.
REQ-027 CPU SHALL hold req_i and addr_i stable while ready_o=0; controller behaviour otherwise undefined.
REQ-028 word_cnt 5-bit, wraps to 0 only at refill start; no overrun past LINE_WORDS-1.

Reset
REQ-029 rst_ni=0 at clock edge: state IDLE, all valid bits 0, word_cnt 0, flush_pending 0, miss_cnt_o 0, mem_req_o 0, mem_addr_o 0, ready_o 0; data/tag arrays need not reset.
REQ-030 Reset mid-REFILL: mem_req_o 0 from next cycle, partially filled line stays invalid.

Verification
REQ-031 Cold miss: req_i=1, addr_i=0x0000_0104 after reset -> REFILL, mem_addr_o 0x0000_0100..0x0000_017C over 32 acks, DONE, then ready_o=1, instr_o=word 1 data, miss_cnt_o=1.
REQ-032 Hit: after REQ-031, addr_i=0x0000_0178 -> ready_o=1 same cycle, instr_o=word 30, no mem_req_o, miss_cnt_o=1.
REQ-033 Conflict: addr_i=0x0000_0904 (same index 2, tag 1) -> refill, then 0x0000_0104 misses again, miss_cnt_o=3.
REQ-034 Ack stalls: mem_ack_i random gaps -> mem_addr_o stable across gaps, all 32 words correct.
REQ-035 Flush: flush_i pulse mid-REFILL -> refill completes, next lookup of same address misses; flush_i in IDLE -> all lines miss.
REQ-036 Reset after 10 acks of a refill -> mem_req_o=0 next cycle, subsequent fetch of that line misses, miss_cnt_o restarts at 1.
